// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss handling for the 2-way set-associative L1.
// Hits answer in CHECK; misses write back a dirty victim, fill, then replay.
module cache_miss_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    input  logic             hit,
    input  logic             compare0,
    input  logic             compare1,
    input  logic [8:0]       tag0,
    input  logic [8:0]       tag1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru_way,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic             way_sel,
    output logic             fill_sel,
    output logic             load_data0,
    output logic             load_data1,
    output logic             load_tag,
    output logic             set_dirty,
    output logic             load_lru,
    output logic             lru_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             victim_q, victim_d;
    logic             replay_q, replay_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;
    logic             hit_inc, miss_inc, wb_inc;
    logic             req;
    logic             unused_offset;

    assign req           = mem_read | mem_write;
    assign unused_offset = ^mem_address[3:0];

    // Next state, victim/replay tracking and all Mealy array/pmem controls
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        replay_d     = replay_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        wb_inc       = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        way_sel      = 1'b0;
        fill_sel     = 1'b0;
        load_data0   = 1'b0;
        load_data1   = 1'b0;
        load_tag     = 1'b0;
        set_dirty    = 1'b0;
        load_lru     = 1'b0;
        lru_in       = 1'b0;
        unique case (state_q)
            CHECK: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = compare0;
                    way_sel  = compare1;
                    hit_inc  = ~replay_q;
                    replay_d = 1'b0;
                    if (mem_write) begin
                        load_data0 = ~compare1;
                        load_data1 = compare1;
                        set_dirty  = 1'b1;
                    end
                end else if (req) begin
                    victim_d = lru_way;
                    miss_inc = 1'b1;
                    state_d  = (lru_way ? dirty1 : dirty0) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                way_sel      = victim_q;
                pmem_address = {victim_q ? tag1 : tag0, mem_address[6:4], 4'h0};
                if (pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                way_sel      = victim_q;
                pmem_address = {mem_address[15:4], 4'h0};
                if (pmem_resp) begin
                    load_data0 = ~victim_q;
                    load_data1 = victim_q;
                    fill_sel   = 1'b1;
                    load_tag   = 1'b1;
                    replay_d   = 1'b1;
                    state_d    = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    // Saturating performance counter increments
    always_comb begin
        hit_d  = (hit_inc && hit_q != CNT_MAX) ? hit_q + 1'b1 : hit_q;
        miss_d = (miss_inc && miss_q != CNT_MAX) ? miss_q + 1'b1 : miss_q;
        wb_d   = (wb_inc && wb_q != CNT_MAX) ? wb_q + 1'b1 : wb_q;
    end

    // State, victim, replay flag and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CHECK;
            victim_q <= 1'b0;
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            replay_q <= replay_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wb_q     <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: random CPU traffic against a transaction-level cache model.
// A narrow-counter twin instance exercises counter saturation.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic        hit, compare0, compare1;
    logic [8:0]  tag0, tag1;
    logic        dirty0, dirty1, lru_way, pmem_resp;

    logic        mem_resp, pmem_read, pmem_write, way_sel, fill_sel;
    logic        load_data0, load_data1, load_tag, set_dirty, load_lru, lru_in;
    logic [15:0] pmem_address, hit_count, miss_count, wb_count;

    logic        s_mem_resp, s_pmem_read, s_pmem_write, s_way_sel, s_fill_sel;
    logic        s_load_data0, s_load_data1, s_load_tag, s_set_dirty;
    logic        s_load_lru, s_lru_in;
    logic [15:0] s_pmem_address;
    logic [2:0]  s_hit_count, s_miss_count, s_wb_count;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .hit(hit), .compare0(compare0),
        .compare1(compare1), .tag0(tag0), .tag1(tag1), .dirty0(dirty0),
        .dirty1(dirty1), .lru_way(lru_way), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .way_sel(way_sel), .fill_sel(fill_sel),
        .load_data0(load_data0), .load_data1(load_data1), .load_tag(load_tag),
        .set_dirty(set_dirty), .load_lru(load_lru), .lru_in(lru_in),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_miss_ctrl #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .hit(hit), .compare0(compare0),
        .compare1(compare1), .tag0(tag0), .tag1(tag1), .dirty0(dirty0),
        .dirty1(dirty1), .lru_way(lru_way), .pmem_resp(pmem_resp),
        .mem_resp(s_mem_resp), .pmem_read(s_pmem_read),
        .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
        .way_sel(s_way_sel), .fill_sel(s_fill_sel),
        .load_data0(s_load_data0), .load_data1(s_load_data1),
        .load_tag(s_load_tag), .set_dirty(s_set_dirty),
        .load_lru(s_load_lru), .lru_in(s_lru_in),
        .hit_count(s_hit_count), .miss_count(s_miss_count),
        .wb_count(s_wb_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // cache contents seen by the hit detector
    bit [8:0]    ctag   [8][2];
    bit          cval   [8][2];
    bit          cdirty [8][2];
    bit          clru   [8];

    // pending pmem operations of the current miss: 1 = writeback, 0 = fill
    bit          op_wb   [$];
    logic [15:0] op_addr [$];
    bit          vic;
    int          lat;
    bit          txn_missed;
    int          m_hit, m_miss, m_wb;

    // CPU side
    bit          active, quiet, rd, wr;
    logic [15:0] a;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [10:0] obs_main();
        return {lru_in, load_lru, set_dirty, load_tag, load_data1, load_data0,
                fill_sel, way_sel, pmem_write, pmem_read, mem_resp};
    endfunction

    function automatic logic [10:0] obs_sat();
        return {s_lru_in, s_load_lru, s_set_dirty, s_load_tag, s_load_data1,
                s_load_data0, s_fill_sel, s_way_sel, s_pmem_write,
                s_pmem_read, s_mem_resp};
    endfunction

    task automatic check_counts();
        check("hit_cnt", 32'(hit_count), 32'(cap(m_hit, 65535)));
        check("miss_cnt", 32'(miss_count), 32'(cap(m_miss, 65535)));
        check("wb_cnt", 32'(wb_count), 32'(cap(m_wb, 65535)));
        check("sat_hit", 32'(s_hit_count), 32'(cap(m_hit, 7)));
        check("sat_miss", 32'(s_miss_count), 32'(cap(m_miss, 7)));
        check("sat_wb", 32'(s_wb_count), 32'(cap(m_wb, 7)));
    endtask

    task automatic drive(input bit no_resp);
        logic [2:0] s;
        logic [8:0] t;
        int k;
        if (!active && !quiet && $urandom_range(3) != 0) begin
            active = 1'b1;
            k = $urandom_range(3);
            case (k)
                0: t = 9'h000;
                1: t = 9'h001;
                2: t = 9'h002;
                default: t = 9'h1FF;
            endcase
            a = {t, 3'($urandom_range(3)), 4'($urandom_range(15))};
            k = $urandom_range(3);
            rd = (k != 1);
            wr = (k == 1 || k == 2);
        end
        mem_read    = active && rd;
        mem_write   = active && wr;
        mem_address = active ? a : 16'($urandom);
        s = mem_address[6:4];
        t = mem_address[15:7];
        compare0 = cval[s][0] && ctag[s][0] == t;
        compare1 = cval[s][1] && ctag[s][1] == t;
        hit      = compare0 | compare1;
        tag0     = ctag[s][0];
        tag1     = ctag[s][1];
        dirty0   = cdirty[s][0];
        dirty1   = cdirty[s][1];
        if (op_wb.size() != 0) begin
            lru_way   = 1'($urandom);
            pmem_resp = (lat == 0) && !(no_resp && !op_wb[0]);
        end else begin
            lru_way   = clru[s];
            pmem_resp = ($urandom_range(3) == 0);
        end
    endtask

    task automatic eval_cycle();
        logic [10:0] e, m;
        logic [2:0]  s;
        logic [8:0]  t;
        bit          w;
        e = '0;
        m = '1;
        s = mem_address[6:4];
        t = mem_address[15:7];
        check_counts();
        if (op_wb.size() == 0) begin
            if ((mem_read || mem_write) && hit) begin
                w = compare1;
                e[0] = 1'b1;
                e[9] = 1'b1;
                e[10] = compare0;
                e[3] = w;
                if (mem_write) begin
                    e[5 + w] = 1'b1;
                    e[8] = 1'b1;
                    cdirty[s][w] = 1'b1;
                end else begin
                    m[4] = 1'b0;
                end
                clru[s] = compare0;
                if (!txn_missed) m_hit++;
                txn_missed = 1'b0;
                active = 1'b0;
            end else if (mem_read || mem_write) begin
                m[3] = 1'b0;
                m[4] = 1'b0;
                m[10] = 1'b0;
                m_miss++;
                txn_missed = 1'b1;
                vic = lru_way;
                if (vic ? dirty1 : dirty0) begin
                    op_wb.push_back(1'b1);
                    op_addr.push_back({vic ? tag1 : tag0, s, 4'h0});
                end
                op_wb.push_back(1'b0);
                op_addr.push_back({mem_address[15:4], 4'h0});
                lat = $urandom_range(4);
            end
        end else begin
            check("pm_addr", 32'(pmem_address), 32'(op_addr[0]));
            check("sat_addr", 32'(s_pmem_address), 32'(op_addr[0]));
            e[2] = op_wb[0];
            e[1] = !op_wb[0];
            e[3] = vic;
            m[10] = 1'b0;
            if (pmem_resp) begin
                if (op_wb[0]) begin
                    m_wb++;
                    m[4] = 1'b0;
                end else begin
                    e[5 + vic] = 1'b1;
                    e[4] = 1'b1;
                    e[7] = 1'b1;
                    ctag[s][vic]   = t;
                    cval[s][vic]   = 1'b1;
                    cdirty[s][vic] = 1'b0;
                end
                void'(op_wb.pop_front());
                void'(op_addr.pop_front());
                lat = $urandom_range(6);
            end else begin
                m[4] = 1'b0;
                if (lat > 0) lat--;
            end
        end
        check("ctl", 32'(obs_main() & m), 32'(e & m));
        check("sat_ctl", 32'(obs_sat() & m), 32'(e & m));
    endtask

    task automatic cycle(input bit no_resp);
        @(negedge clk);
        drive(no_resp);
        #1;
        eval_cycle();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b1;
        #1;
        check(tag, 32'(obs_main()), 32'd0);
        check("idle_cnt", 32'({hit_count, miss_count}), 32'd0);
        check("idle_wb", 32'(wb_count), 32'd0);
    endtask

    task automatic clear_model();
        op_wb.delete();
        op_addr.delete();
        active     = 1'b0;
        txn_missed = 1'b0;
        m_hit      = 0;
        m_miss     = 0;
        m_wb       = 0;
        lat        = 0;
    endtask

    initial begin
        int fc;
        int guard;
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        hit         = 1'b0;
        compare0    = 1'b0;
        compare1    = 1'b0;
        tag0        = 9'h000;
        tag1        = 9'h000;
        dirty0      = 1'b0;
        dirty1      = 1'b0;
        lru_way     = 1'b0;
        pmem_resp   = 1'b0;
        quiet       = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        check_idle("rst_ctl");

        repeat (3000) cycle(1'b0);

        // drain traffic, then reset in the third FILL cycle of a clean miss
        quiet = 1'b1;
        guard = 0;
        while ((active || op_wb.size() != 0) && guard < 500) begin
            cycle(1'b0);
            guard++;
        end
        check("idle_wait", 32'(op_wb.size()), 32'd0);
        active = 1'b1;
        a      = {9'h155, 3'd2, 4'h4};
        rd     = 1'b1;
        wr     = 1'b0;
        fc     = 0;
        guard  = 0;
        while (fc < 3 && guard < 500) begin
            @(negedge clk);
            if (op_wb.size() != 0 && !op_wb[0]) begin
                fc++;
                if (fc == 3) reset = 1'b1;
            end
            drive(1'b1);
            #1;
            eval_cycle();
            guard++;
        end
        check("fill_wait", 32'(fc), 32'd3);
        clear_model();
        check_idle("rst_fill");
        quiet = 1'b0;

        repeat (3000) cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
